// File: rtl/dmem_line_ctrl.sv
// rtl/dmem_line_ctrl.sv - fixed-latency 256-bit line memory behind the data cache miss path
// Optional macro DMEM_LINE_CTRL_STATS_EN adds read/write completion counters.
module dmem_line_ctrl #(
   parameter int LATENCY     = 10,
   parameter int DEPTH_LINES = 512,
   parameter int IDX_W       = 9
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         enable_i,
   input  logic         write_i,
   input  logic [31:0]  addr_i,
   input  logic [255:0] data_i,
   output logic         ack_o,
   output logic [255:0] data_o,
   output logic         busy_o
`ifdef DMEM_LINE_CTRL_STATS_EN
   ,
   output logic [31:0]  rd_cnt_o,
   output logic [31:0]  wr_cnt_o
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   localparam logic [7:0] LAT_C = 8'(LATENCY);

   state_t         r_state;
   state_t         w_next;
   logic           w_accept;
   logic           w_fire;
   logic [7:0]     r_cnt;
   logic           r_ack;
   logic           r_busy;
   logic           r_wr;
   logic [IDX_W-1:0] r_idx;
   logic [255:0]   r_wdata;
   logic [255:0]   r_rdata;
   logic [255:0]   r_mem [DEPTH_LINES];
   logic           w_unused_addr;

   // Offset bits and the aliased upper bits take no part in line selection.
   assign w_unused_addr = ^{addr_i[31:IDX_W+5], addr_i[4:0]};

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_fire   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (enable_i) begin
               w_accept = 1'b1;
               w_next   = S_WAIT;
            end
         end
         S_WAIT: begin
            if (r_cnt == LAT_C) begin
               w_fire = 1'b1;
               w_next = S_ACK;
            end
         end
         S_ACK: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_cnt   <= '0;
         r_ack   <= 1'b0;
         r_busy  <= 1'b0;
         r_wr    <= 1'b0;
         r_idx   <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         r_ack  <= w_fire;
         r_busy <= (w_next != S_IDLE);
         if (w_accept) begin
            r_wr    <= write_i;
            r_idx   <= addr_i[IDX_W+4:5];
            r_wdata <= data_i;
            r_cnt   <= 8'd1;
         end else if ((r_state == S_WAIT) && !w_fire) begin
            r_cnt <= r_cnt + 8'd1;
         end else if (r_state == S_ACK) begin
            r_cnt <= '0;
         end
         if (w_fire && !r_wr) begin
            r_rdata <= r_mem[r_idx];
         end
      end
   end

   // Array is deliberately left out of reset; an abort keeps the FSM out of WAIT so no write lands.
   always_ff @(posedge clk_i) begin
      if (w_fire && r_wr) begin
         r_mem[r_idx] <= r_wdata;
      end
   end

`ifdef DMEM_LINE_CTRL_STATS_EN
   logic [31:0] r_rd_cnt;
   logic [31:0] r_wr_cnt;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_rd_cnt <= '0;
         r_wr_cnt <= '0;
      end else if (w_fire) begin
         if (r_wr) begin
            r_wr_cnt <= r_wr_cnt + 32'd1;
         end else begin
            r_rd_cnt <= r_rd_cnt + 32'd1;
         end
      end
   end

   assign rd_cnt_o = r_rd_cnt;
   assign wr_cnt_o = r_wr_cnt;
`endif

   assign ack_o  = r_ack;
   assign data_o = r_rdata;
   assign busy_o = r_busy;

endmodule

// File: tb/tb_dmem_line_ctrl.sv
// tb/tb_dmem_line_ctrl.sv - directed self-checking bench for dmem_line_ctrl
// Stats checks are compiled in when DMEM_LINE_CTRL_STATS_EN is defined.
module tb_dmem_line_ctrl;

   localparam logic [255:0] PA5 = {32{8'hA5}};
   localparam logic [255:0] P11 = {32{8'h11}};
   localparam logic [255:0] PFF = {32{8'hFF}};
   localparam logic [255:0] P3  = {32{8'h33}};
   localparam logic [255:0] P7  = {32{8'h77}};
   localparam logic [255:0] P3C = {32{8'h3C}};

   logic         clk;
   logic         rst;
   logic         en;
   logic         wr;
   logic [31:0]  addr;
   logic [255:0] wdata;
   logic         ack;
   logic [255:0] rdata;
   logic         busy;
`ifdef DMEM_LINE_CTRL_STATS_EN
   logic [31:0]  rd_cnt;
   logic [31:0]  wr_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   dmem_line_ctrl dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .enable_i (en),
      .write_i  (wr),
      .addr_i   (addr),
      .data_i   (wdata),
      .ack_o    (ack),
      .data_o   (rdata),
      .busy_o   (busy)
`ifdef DMEM_LINE_CTRL_STATS_EN
      ,
      .rd_cnt_o (rd_cnt),
      .wr_cnt_o (wr_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_vec(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input logic w, input logic [31:0] a, input logic [255:0] d,
                         output int lat, output logic [255:0] q);
      en = 1'b1; wr = w; addr = a; wdata = d;
      tick();
      en = 1'b0; wdata = '0;
      lat = 0;
      for (int k = 0; k < 300; k++) begin
         tick();
         lat++;
         if (ack) break;
      end
      q = rdata;
      check_vec("busy_in_ack", 256'(busy), 256'(1));
      tick();
      check_vec("ack_one_cycle", 256'(ack), 256'(0));
      check_vec("busy_after_ack", 256'(busy), 256'(0));
   endtask

   initial begin
      int           lat;
      int           t1, t2, n_ack;
      logic [255:0] q;

      rst = 1'b0; en = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
      t1 = 0; t2 = 0;

      // reset held while inputs toggle
      for (int i = 0; i < 4; i++) begin
         en = ~en; wr = ~wr; addr = $urandom; wdata = {8{$urandom}};
         tick();
      end
      check_vec("rst_ack", 256'(ack), 256'(0));
      check_vec("rst_data", rdata, 256'(0));
      check_vec("rst_busy", 256'(busy), 256'(0));
      en = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      check_vec("idle_busy", 256'(busy), 256'(0));
      check_vec("idle_ack", 256'(ack), 256'(0));

      // write then read the same line through a different offset
      do_req(1'b1, 32'h0000_0040, PA5, lat, q);
      check_vec("wr_latency", 256'(lat), 256'(10));
      do_req(1'b0, 32'h0000_005C, '0, lat, q);
      check_vec("rd_latency", 256'(lat), 256'(10));
      check_vec("rd_data", q, PA5);
      do_req(1'b1, 32'h0000_0060, PFF, lat, q);
      check_vec("data_held_over_write", rdata, PA5);

      // back-to-back: write idx 3 then read idx 7, enable held across ACK
      dut.r_mem[7] = P7;
      en = 1'b1; wr = 1'b1; addr = 32'(3 << 5); wdata = P3;
      tick();
      n_ack = 0;
      for (int t = 1; t <= 40; t++) begin
         tick();
         if (ack) begin
            n_ack++;
            if (n_ack == 1) begin
               t1 = t; wr = 1'b0; addr = 32'(7 << 5);
            end else begin
               t2 = t; q = rdata; en = 1'b0;
            end
         end
      end
      check_vec("b2b_ack_count", 256'(n_ack), 256'(2));
      check_vec("b2b_first_ack", 256'(t1), 256'(10));
      check_vec("b2b_ack_spacing", 256'(t2 - t1), 256'(12));
      check_vec("b2b_rd_data", q, P7);
      do_req(1'b0, 32'(3 << 5), '0, lat, q);
      check_vec("b2b_wr_landed", q, P3);

      // abort a write to idx 5 with reset at cnt=4
      dut.r_mem[5] = P11;
      en = 1'b1; wr = 1'b1; addr = 32'(5 << 5); wdata = PFF;
      tick();
      en = 1'b0;
      repeat (3) tick();
      check_vec("abort_cnt", 256'(dut.r_cnt), 256'(4));
      rst = 1'b0;
      #1;
      check_vec("abort_ack", 256'(ack), 256'(0));
      check_vec("abort_busy", 256'(busy), 256'(0));
      check_vec("abort_data", rdata, 256'(0));
      tick();
      rst = 1'b1;
      n_ack = 0;
      for (int t = 0; t < 15; t++) begin
         tick();
         if (ack) n_ack++;
      end
      check_vec("abort_no_ack", 256'(n_ack), 256'(0));
      do_req(1'b0, 32'(5 << 5), '0, lat, q);
      check_vec("abort_mem_kept", q, P11);

      // aliasing: 0x4020 maps to the same line as 0x0020
      do_req(1'b1, 32'h0000_0020, P3C, lat, q);
      do_req(1'b0, 32'h0000_4020, '0, lat, q);
      check_vec("alias_data", q, P3C);

`ifdef DMEM_LINE_CTRL_STATS_EN
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check_vec("stats_rst_rd", 256'(rd_cnt), 256'(0));
      check_vec("stats_rst_wr", 256'(wr_cnt), 256'(0));
      for (int i = 0; i < 3; i++) do_req(1'b1, 32'(i << 5), PA5, lat, q);
      for (int i = 0; i < 2; i++) do_req(1'b0, 32'(i << 5), '0, lat, q);
      check_vec("stats_wr", 256'(wr_cnt), 256'(3));
      check_vec("stats_rd", 256'(rd_cnt), 256'(2));
      en = 1'b1; wr = 1'b0; addr = '0;
      tick();
      en = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      #1;
      check_vec("stats_abort_wr", 256'(wr_cnt), 256'(0));
      check_vec("stats_abort_rd", 256'(rd_cnt), 256'(0));
      tick();
      rst = 1'b1;
      repeat (15) tick();
      check_vec("stats_abort_uncounted", 256'(rd_cnt), 256'(0));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
